// File: rtl/exposure_ctrl_pkg.sv
// exposure_ctrl_pkg: shared state encoding and default widths for the exposure trigger controller
package exposure_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        EXPOSE  = 3'd3,
        READOUT = 3'd4
    } state_t;
    localparam int CNT_W_DEF   = 24;
    localparam int FRAME_W_DEF = 16;
endpackage

// File: rtl/trig_glitch_filter.sv
// trig_glitch_filter: 2-flop synchroniser, FILTER_LEN-sample agreement filter and rising-edge detect
// Ports: clk, rst (async, active-high), in (raw async input), level (filtered level), rise (one-cycle edge)
module trig_glitch_filter #(
    parameter int FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise
);
    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] hist;
    logic                  prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            hist  <= '0;
            level <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync  <= {sync[0], in};
            hist  <= {hist[FILTER_LEN-2:0], sync[1]};
            level <= &hist ? 1'b1 : (~|hist ? 1'b0 : level);
            prev  <= level;
        end
    end
    assign rise = level & ~prev;
endmodule

// File: rtl/exposure_trigger_ctrl.sv
// exposure_trigger_ctrl: sequences arm, delay, exposure window and readout handshake per qualified trigger edge
// Ports: clk, rst (async, active-high), trig_in, arm, abort, cont, delay_len, exp_len, readout_done;
//        exposure, readout_req, busy, missed, frame_count
module exposure_trigger_ctrl
    import exposure_ctrl_pkg::*;
#(
    parameter int FILTER_LEN = 4,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int FRAME_W    = FRAME_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig_in,
    input  logic               arm,
    input  logic               abort,
    input  logic               cont,
    input  logic [CNT_W-1:0]   delay_len,
    input  logic [CNT_W-1:0]   exp_len,
    input  logic               readout_done,
    output logic               exposure,
    output logic               readout_req,
    output logic               busy,
    output logic               missed,
    output logic [FRAME_W-1:0] frame_count
);
    state_t             state, next;
    logic               trig_edge;
    logic [CNT_W-1:0]   cnt, exp_q, exp_eff;

    trig_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk   (clk),
        .rst   (rst),
        .in    (trig_in),
        .level (),
        .rise  (trig_edge)
    );

    always_comb begin
        next    = state;
        exp_eff = (exp_len == '0) ? CNT_W'(1) : exp_len;
        case (state)
            IDLE:    if (arm) next = ARMED;
            ARMED:   if (trig_edge) next = (delay_len != '0) ? DELAY : EXPOSE;
            DELAY:   if (cnt == CNT_W'(1)) next = EXPOSE;
            EXPOSE:  if (cnt == CNT_W'(1)) next = READOUT;
            READOUT: if (readout_done) next = cont ? ARMED : IDLE;
            default: next = IDLE;
        endcase
        if (abort) next = IDLE;
    end

    // cnt holds the remaining delay, then is reloaded with the latched exposure length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            exp_q       <= '0;
            exposure    <= 1'b0;
            readout_req <= 1'b0;
            missed      <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= next;
            exposure    <= (next == EXPOSE);
            readout_req <= (next == READOUT);
            missed      <= !abort && trig_edge && (state inside {DELAY, EXPOSE, READOUT});
            if (state == READOUT && readout_done && !abort)
                frame_count <= frame_count + 1'b1;
            if (state == ARMED && (next inside {DELAY, EXPOSE})) begin
                exp_q <= exp_eff;
                cnt   <= (delay_len != '0) ? delay_len : exp_eff;
            end else if (state == DELAY && next == EXPOSE) begin
                cnt <= exp_q;
            end else if (state inside {DELAY, EXPOSE}) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_exposure_trigger_ctrl.sv
// tb_exposure_trigger_ctrl: directed self-checking bench for exposure_trigger_ctrl
module tb_exposure_trigger_ctrl;
    import exposure_ctrl_pkg::*;
    localparam int CNT_W   = 24;
    localparam int FRAME_W = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               trig_in = 1'b0, arm = 1'b0, abort = 1'b0, cont = 1'b0, readout_done = 1'b0;
    logic [CNT_W-1:0]   delay_len = '0, exp_len = '0;
    logic               exposure, readout_req, busy, missed;
    logic [FRAME_W-1:0] frame_count;
    int                 n_tests = 0, n_fail = 0;
    int                 lat, width, edge_k, mcnt, ecnt;

    exposure_trigger_ctrl #(.FILTER_LEN(4), .CNT_W(CNT_W), .FRAME_W(FRAME_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .trig_in      (trig_in),
        .arm          (arm),
        .abort        (abort),
        .cont         (cont),
        .delay_len    (delay_len),
        .exp_len      (exp_len),
        .readout_done (readout_done),
        .exposure     (exposure),
        .readout_req  (readout_req),
        .busy         (busy),
        .missed       (missed),
        .frame_count  (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick(1);
        arm = 1'b0;
    endtask

    // raise trig_in, measure cycles to first exposure sample and exposure width
    task automatic run_trigger(output int l, output int w);
        trig_in = 1'b1;
        l = 0;
        w = 0;
        while (!exposure && l < 60) begin
            tick(1);
            l++;
        end
        while (exposure && w < 100) begin
            w++;
            tick(1);
        end
    endtask

    task automatic frame();
        run_trigger(lat, width);
        trig_in = 1'b0;
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        tick(8);
    endtask

    initial begin
        tick(3);
        check("rst_exposure", 32'(exposure), 0);
        check("rst_readout_req", 32'(readout_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_missed", 32'(missed), 0);
        check("rst_frame_count", 32'(frame_count), 0);
        rst = 1'b0;
        tick(2);

        // qualified trigger, no delay, exposure 5
        exp_len = 5;
        pulse_arm();
        check("armed_state", 32'(dut.state), 32'(ARMED));
        trig_in = 1'b1;
        lat = 0;
        edge_k = 0;
        while (!exposure && lat < 60) begin
            tick(1);
            lat++;
            if (dut.trig_edge && edge_k == 0) edge_k = lat;
        end
        check("t1_edge_latency", 32'(edge_k), 7);
        check("t1_exp_latency", 32'(lat), 8);
        width = 0;
        while (exposure && width < 100) begin
            width++;
            tick(1);
        end
        check("t1_exp_width", 32'(width), 5);
        check("t1_readout_req", 32'(readout_req), 1);
        tick(3);
        check("t1_readout_hold", 32'(readout_req), 1);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        check("t1_frame_count", 32'(frame_count), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_readout_drop", 32'(readout_req), 0);
        trig_in = 1'b0;
        tick(8);

        // glitch rejection
        pulse_arm();
        ecnt = 0;
        mcnt = 0;
        for (int i = 0; i < 10; i++) begin
            trig_in = 1'b1;
            for (int j = 0; j < 6; j++) begin
                if (j == 3) trig_in = 1'b0;
                tick(1);
                ecnt += int'(dut.trig_edge);
                mcnt += int'(exposure);
            end
        end
        tick(8);
        check("glitch_edges", 32'(ecnt), 0);
        check("glitch_exposure", 32'(mcnt), 0);
        check("glitch_state", 32'(dut.state), 32'(ARMED));

        // delay 10, zero exposure length
        delay_len = 10;
        exp_len = 0;
        run_trigger(lat, width);
        check("t3_exp_latency", 32'(lat), 18);
        check("t3_exp_width", 32'(width), 1);
        trig_in = 1'b0;
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        check("t3_frame_count", 32'(frame_count), 2);
        check("t3_state", 32'(dut.state), 32'(IDLE));
        tick(8);

        // missed trigger during exposure, continuous mode
        cont = 1'b1;
        delay_len = 0;
        exp_len = 20;
        pulse_arm();
        trig_in = 1'b1;
        lat = 0;
        while (!exposure && lat < 60) begin
            tick(1);
            lat++;
        end
        check("t4_exp_latency", 32'(lat), 8);
        exp_len = 3;
        delay_len = 7;
        trig_in = 1'b0;
        width = 1;
        mcnt = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (i == 8) trig_in = 1'b1;
            mcnt += int'(missed);
            if (!exposure) break;
            width++;
        end
        check("t4_missed_pulses", 32'(mcnt), 1);
        check("t4_exp_width", 32'(width), 20);
        check("t4_readout_req", 32'(readout_req), 1);
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        check("t4_frame_count", 32'(frame_count), 3);
        check("t4_rearmed", 32'(dut.state), 32'(ARMED));
        trig_in = 1'b0;
        tick(8);
        delay_len = 0;
        run_trigger(lat, width);
        check("t4_frame2_latency", 32'(lat), 8);
        check("t4_frame2_width", 32'(width), 3);
        trig_in = 1'b0;
        readout_done = 1'b1;
        tick(1);
        readout_done = 1'b0;
        check("t4_frame2_count", 32'(frame_count), 4);
        tick(8);

        // abort in third exposure cycle
        exp_len = 10;
        trig_in = 1'b1;
        lat = 0;
        while (!exposure && lat < 60) begin
            tick(1);
            lat++;
        end
        tick(2);
        check("t5_exposing", 32'(exposure), 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t5_abort_exposure", 32'(exposure), 0);
        check("t5_abort_busy", 32'(busy), 0);
        check("t5_abort_frames", 32'(frame_count), 4);
        trig_in = 1'b0;
        tick(8);

        // async reset during readout, trig_in held high through release
        exp_len = 2;
        pulse_arm();
        trig_in = 1'b1;
        lat = 0;
        while (!readout_req && lat < 60) begin
            tick(1);
            lat++;
        end
        check("t6_in_readout", 32'(readout_req), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_readout_req", 32'(readout_req), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_frames", 32'(frame_count), 0);
        tick(2);
        rst = 1'b0;
        ecnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            ecnt += int'(dut.trig_edge);
        end
        check("t6_single_edge", 32'(ecnt), 1);
        check("t6_idle_after", 32'(busy), 0);
        trig_in = 1'b0;
        tick(8);

        // frame counter wrap at FRAME_W=4
        cont = 1'b1;
        exp_len = 1;
        pulse_arm();
        for (int f = 1; f <= 16; f++) begin
            frame();
            if (f == 15) check("wrap_15", 32'(frame_count), 15);
        end
        check("wrap_16", 32'(frame_count), 0);
        check("wrap_width", 32'(width), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/exposure_trigger_ctrl.md
Name: exposure_trigger_ctrl

Overview:
Sequences one camera exposure per qualified external trigger edge. The raw trigger pin is synchronised, glitch-filtered by an internal filter sub-module and edge-detected. A trigger FSM then runs arm, optional delay, exposure window and readout handshake, and returns to idle or re-arms. It sits between the external trigger/shutter pin and the sensor timing/readout logic.

Parameters:
FILTER_LEN, 4, consecutive equal synchronised samples required to change the filtered level (2..16)
CNT_W, 24, width of the delay and exposure length counters
FRAME_W, 16, width of the frame counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
trig_in  input  1  raw asynchronous external trigger
arm  input  1  single-cycle pulse; leaves IDLE for ARMED
abort  input  1  level; forces IDLE
cont  input  1  1 = re-arm after each frame, 0 = single shot
delay_len  input  CNT_W  trigger-to-exposure delay in cycles; sampled at the trigger edge
exp_len  input  CNT_W  exposure length in cycles; sampled at the trigger edge; 0 treated as 1
readout_done  input  1  readout finished; level or pulse
exposure  output  1  registered exposure window
readout_req  output  1  registered readout request
busy  output  1  state is not IDLE
missed  output  1  one-cycle pulse: qualified trigger edge while in DELAY, EXPOSE or READOUT
frame_count  output  FRAME_W  completed frames; wraps modulo 2^FRAME_W

Behaviour:
- Reset (async, active-high): state IDLE. exposure, readout_req, busy and missed are 0. frame_count is 0. Synchroniser, filter and edge register are cleared to 0. If trig_in is high at reset release, a rising edge is produced after qualification.
- Front end: 2-flop synchroniser, then trig_glitch_filter, then rising-edge detect giving trig_edge.
  - Filtered level goes high after FILTER_LEN consecutive 1 samples; it goes low after FILTER_LEN consecutive 0 samples.
  - trig_edge pulses for one cycle. It is first asserted exactly 2+FILTER_LEN+1 cycles after trig_in rises, with trig_in then held stable.
  - Pulses shorter than FILTER_LEN cycles produce no edge.
- FSM states: IDLE, ARMED, DELAY, EXPOSE, READOUT.
- IDLE -> ARMED: on arm.
- ARMED -> DELAY or EXPOSE: on trig_edge, latch delay_len and exp_len. Go to DELAY if the latched delay_len > 0, else EXPOSE.
- DELAY: stay exactly delay_len cycles, then EXPOSE.
- EXPOSE: exposure = 1 for exactly max(exp_len, 1) cycles. It first asserts the cycle after the trig_edge cycle when delay_len is 0. Then go to READOUT.
- READOUT: readout_req = 1 until readout_done is sampled high. On that cycle frame_count increments and readout_req drops the next cycle. Next state is ARMED if cont = 1, else IDLE.
- abort: from any state, the next state is IDLE and exposure/readout_req go to 0 the next cycle. frame_count is not incremented. abort has priority over every other event.
- arm outside IDLE is ignored. readout_done outside READOUT is ignored.
- trig_edge in IDLE: ignored, no missed pulse.
- trig_edge in DELAY, EXPOSE or READOUT: missed pulses for 1 cycle and the current frame is unaffected.
- arm and trig_edge in the same cycle: arm wins, the edge is ignored, no missed pulse.
- Changes to delay_len and exp_len after the trigger edge do not affect the frame in progress.
- busy is combinational from the registered state: busy = (state != IDLE).

Decomposition:
- Shared package exposure_ctrl_pkg holds:
  - the state enum with a fixed 3-bit encoding: IDLE=0, ARMED=1, DELAY=2, EXPOSE=3, READOUT=4;
  - defaults for CNT_W and FRAME_W.
- One sub-module, trig_glitch_filter, containing the synchroniser, the FILTER_LEN shift-history filter and the edge detect. Ports: clk, rst, in, level, rise.
- The top level contains only the FSM and the counters.

Test Plan:
- Qualified trigger, FILTER_LEN=4, delay_len=0, exp_len=5, cont=0: arm, then hold trig_in high. Required: trig_edge 7 cycles after the rise; exposure high exactly 5 cycles starting the next cycle; then readout_req = 1. Assert readout_done 3 cycles later: frame_count = 1, state IDLE, busy = 0.
- Glitch rejection: arm, then 3-cycle trig_in pulses repeated 10 times. Required: no trig_edge, state stays ARMED, exposure = 0.
- Delay and zero exposure, delay_len=10, exp_len=0: the first exposure cycle is exactly 11 cycles after trig_edge, and exposure lasts 1 cycle.
- Missed triggers, cont=1, exp_len=20: a second qualified edge during EXPOSE gives missed = 1 for 1 cycle and the exposure still lasts 20 cycles. After readout_done the state is ARMED and the next edge starts frame 2.
- Abort and reset mid-operation:
  - abort in cycle 3 of EXPOSE: exposure = 0 next cycle, state IDLE, frame_count unchanged.
  - rst asserted during READOUT: all outputs 0 immediately (async).
  - trig_in held high through reset release: exactly one trig_edge afterwards.
- Frame counter wrap, FRAME_W=4: 16 completed frames -> frame_count returns to 0.
